// File: rtl/ldl_crc32_mch_check.sv
// Multi-channel streaming CRC-32 frame checker.
// Per-channel running CRC/length, one result per frame.

module ldl_crc32_next #(
  parameter int NUM = 4,
  parameter int NBW = 3
) (
  input  logic [31:0]      crc_in,
  input  logic [8*NUM-1:0] data,
  input  logic [NBW-1:0]   nb,
  output logic [31:0]      crc_out
);

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic [31:0] c;
  logic        fb;

  // Fold the first nb bytes of the beat, MSB first
  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (NBW'(i) < nb) begin
        for (int b = 7; b >= 0; b--) begin
          fb = c[31] ^ data[8*(NUM-1-i)+b];
          c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
      end
    end
    crc_out = c;
  end

endmodule

module ldl_crc32_mch_check #(
  parameter int NUM   = 4,
  parameter int CH    = 1,
  parameter int LEN_W = 16,
  parameter int CNT_W = 16,
  localparam int BW   = (NUM > 1) ? $clog2(NUM) : 1,
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [8*NUM-1:0] s_data,
  input  logic [BW-1:0]    s_bnum,
  input  logic             s_eof,
  input  logic             s_abort,
  input  logic [CW-1:0]    s_ch,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CW-1:0]    m_ch,
  output logic             m_err,
  output logic [LEN_W-1:0] m_len,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam int NBW = BW + 1;
  localparam int SW  = LEN_W + 1;
  localparam logic [31:0] INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] RES  = 32'hC704_DD7B;

  logic [31:0]      crc_all [CH];
  logic [LEN_W-1:0] len_all [CH];

  logic             acc;
  logic             fin;
  logic             ok;
  logic [NBW-1:0]   nb;
  logic [31:0]      crc_cur;
  logic [31:0]      crc_nxt;
  logic [LEN_W-1:0] len_cur;
  logic [LEN_W-1:0] len_nxt;
  logic [SW-1:0]    len_sum;

  assign s_ready = !m_valid || m_ready;
  assign acc     = s_valid && s_ready;
  assign fin     = acc && s_eof && !s_abort;

  assign crc_cur = crc_all[s_ch];
  assign len_cur = len_all[s_ch];

  // Bytes in this beat: only an eof beat may be partial
  always_comb begin
    nb = NBW'(NUM);
    if (s_eof && (s_bnum != '0)) begin
      nb = NBW'(s_bnum);
    end
  end

  ldl_crc32_next #(
    .NUM (NUM),
    .NBW (NBW)
  ) u_crc (
    .crc_in  (crc_cur),
    .data    (s_data),
    .nb      (nb),
    .crc_out (crc_nxt)
  );

  assign len_sum = {1'b0, len_cur} + SW'(nb);
  assign len_nxt = len_sum[LEN_W] ? '1
                 : len_sum[LEN_W-1:0];
  assign ok      = (crc_nxt == RES);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic             hit;
    logic [31:0]      crc_r;
    logic [LEN_W-1:0] len_r;

    assign hit        = acc && (s_ch == CW'(g));
    assign crc_all[g] = crc_r;
    assign len_all[g] = len_r;

    // Channel state: restart on abort/eof, else accumulate
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        crc_r <= INIT;
        len_r <= '0;
      end else if (hit) begin
        if (s_abort || s_eof) begin
          crc_r <= INIT;
          len_r <= '0;
        end else begin
          crc_r <= crc_nxt;
          len_r <= len_nxt;
        end
      end
    end
  end

  // Result register: load on frame end, drop on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ch    <= '0;
      m_err   <= 1'b0;
      m_len   <= '0;
    end else if (fin) begin
      m_valid <= 1'b1;
      m_ch    <= s_ch;
      m_err   <= !ok;
      m_len   <= len_nxt;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Saturating good/bad counters; clear still keeps a same-cycle hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (clr_cnt) begin
      good_cnt <= CNT_W'(fin && ok);
      bad_cnt  <= CNT_W'(fin && !ok);
    end else if (fin) begin
      if (ok && !(&good_cnt)) begin
        good_cnt <= good_cnt + 1'b1;
      end
      if (!ok && !(&bad_cnt)) begin
        bad_cnt <= bad_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ldl_crc32_mch_check.sv
// Directed bench for ldl_crc32_mch_check.
// Frame: "123456789" + FC 89 19 18 (13 bytes).

module tb_ldl_crc32_mch_check;

  localparam int NUM   = 4;
  localparam int CH    = 2;
  localparam int LEN_W = 5;
  localparam int CNT_W = 4;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [1:0]  s_bnum;
  logic        s_eof;
  logic        s_abort;
  logic [0:0]  s_ch;
  logic        m_valid;
  logic        m_ready;
  logic [0:0]  m_ch;
  logic        m_err;
  logic [4:0]  m_len;
  logic        clr_cnt;
  logic [3:0]  good_cnt;
  logic [3:0]  bad_cnt;

  int total;
  int bad;

  ldl_crc32_mch_check #(
    .NUM   (NUM),
    .CH    (CH),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_bnum   (s_bnum),
    .s_eof    (s_eof),
    .s_abort  (s_abort),
    .s_ch     (s_ch),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_ch     (m_ch),
    .m_err    (m_err),
    .m_len    (m_len),
    .clr_cnt  (clr_cnt),
    .good_cnt (good_cnt),
    .bad_cnt  (bad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && s_valid) begin
      assert (int'(s_ch) < CH)
        else $error("s_ch out of range");
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] fw(input int k, input logic cor);
    case (k)
      0:       fw = 32'h3132_3334;
      1:       fw = cor ? 32'h3436_3738 : 32'h3536_3738;
      2:       fw = 32'h39FC_8919;
      default: fw = 32'h1800_0000;
    endcase
  endfunction

  task automatic drive(input logic c, input logic [31:0] d,
                       input logic e, input logic [1:0] bn,
                       input logic ab);
    int n;
    s_ch    = c;
    s_data  = d;
    s_eof   = e;
    s_bnum  = bn;
    s_abort = ab;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!s_ready) begin
      bad++;
      $display("FAIL drive_timeout ready=%0b want=1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_eof   = 1'b0;
    s_abort = 1'b0;
  endtask

  task automatic head(input logic c, input logic cor);
    for (int k = 0; k < 3; k++) drive(c, fw(k, cor), 1'b0, 2'd0, 1'b0);
  endtask

  task automatic tail(input logic c);
    drive(c, fw(3, 1'b0), 1'b1, 2'd1, 1'b0);
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%0b want=0", m_valid);
    end
    total++;
    if (m_ch !== 1'b0 || m_err !== 1'b0 || m_len !== 5'd0) begin
      bad++;
      $display("FAIL rst_out got ch=%0d err=%0b len=%0d want 0 0 0",
               m_ch, m_err, m_len);
    end
    total++;
    if (good_cnt !== 4'd0 || bad_cnt !== 4'd0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d/%0d want=0/0", good_cnt, bad_cnt);
    end
    total++;
    if (s_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%0b want=1", s_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good();
    head(1'b0, 1'b0);
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL good_early got=%0b want=0", m_valid);
    end
    tail(1'b0);
    total++;
    if (m_valid !== 1'b1 || m_ch !== 1'b0) begin
      bad++;
      $display("FAIL good_valid got v=%0b ch=%0d want 1 0", m_valid, m_ch);
    end
    total++;
    if (m_err !== 1'b0 || m_len !== 5'd13) begin
      bad++;
      $display("FAIL good_res got err=%0b len=%0d want 0 13", m_err, m_len);
    end
    total++;
    if (good_cnt !== 4'd1 || bad_cnt !== 4'd0) begin
      bad++;
      $display("FAIL good_cnt got=%0d/%0d want=1/0", good_cnt, bad_cnt);
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL good_consume got=%0b want=0", m_valid);
    end
  endtask

  task automatic test_bad();
    head(1'b0, 1'b1);
    tail(1'b0);
    total++;
    if (m_valid !== 1'b1 || m_err !== 1'b1 || m_len !== 5'd13) begin
      bad++;
      $display("FAIL bad_res got v=%0b err=%0b len=%0d want 1 1 13",
               m_valid, m_err, m_len);
    end
    total++;
    if (good_cnt !== 4'd1 || bad_cnt !== 4'd1) begin
      bad++;
      $display("FAIL bad_cnt got=%0d/%0d want=1/1", good_cnt, bad_cnt);
    end
  endtask

  task automatic test_interleave();
    clear_counters();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, fw(k, 1'b0), 1'b0, 2'd0, 1'b0);
      drive(1'b1, fw(k, 1'b1), 1'b0, 2'd0, 1'b0);
    end
    tail(1'b0);
    total++;
    if (m_valid !== 1'b1 || m_ch !== 1'b0 || m_err !== 1'b0 ||
        m_len !== 5'd13) begin
      bad++;
      $display("FAIL ilv_ch0 got v=%0b ch=%0d err=%0b len=%0d want 1 0 0 13",
               m_valid, m_ch, m_err, m_len);
    end
    tail(1'b1);
    total++;
    if (m_valid !== 1'b1 || m_ch !== 1'b1 || m_err !== 1'b1 ||
        m_len !== 5'd13) begin
      bad++;
      $display("FAIL ilv_ch1 got v=%0b ch=%0d err=%0b len=%0d want 1 1 1 13",
               m_valid, m_ch, m_err, m_len);
    end
    total++;
    if (good_cnt !== 4'd1 || bad_cnt !== 4'd1) begin
      bad++;
      $display("FAIL ilv_cnt got=%0d/%0d want=1/1", good_cnt, bad_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    clear_counters();
    m_ready = 1'b0;
    head(1'b1, 1'b0);
    head(1'b0, 1'b0);
    tail(1'b0);
    total++;
    if (m_valid !== 1'b1 || m_ch !== 1'b0 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_first got v=%0b ch=%0d rdy=%0b want 1 0 0",
               m_valid, m_ch, s_ready);
    end
    s_ch    = 1'b1;
    s_data  = fw(3, 1'b0);
    s_bnum  = 2'd1;
    s_eof   = 1'b1;
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (m_valid !== 1'b1 || m_ch !== 1'b0 || m_err !== 1'b0 ||
          m_len !== 5'd13 || s_ready !== 1'b0 || good_cnt !== 4'd1) begin
        bad++;
        $display("FAIL stall_hold got v=%0b ch=%0d err=%0b len=%0d rdy=%0b g=%0d want 1 0 0 13 0 1",
                 m_valid, m_ch, m_err, m_len, s_ready, good_cnt);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    s_eof   = 1'b0;
    total++;
    if (m_valid !== 1'b1 || m_ch !== 1'b1 || m_err !== 1'b0 ||
        m_len !== 5'd13) begin
      bad++;
      $display("FAIL stall_second got v=%0b ch=%0d err=%0b len=%0d want 1 1 0 13",
               m_valid, m_ch, m_err, m_len);
    end
    total++;
    if (good_cnt !== 4'd2) begin
      bad++; $display("FAIL stall_cnt got=%0d want=2", good_cnt);
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL stall_drain got=%0b want=0", m_valid);
    end
  endtask

  task automatic test_abort();
    clear_counters();
    drive(1'b0, fw(0, 1'b0), 1'b0, 2'd0, 1'b0);
    drive(1'b0, fw(1, 1'b0), 1'b0, 2'd0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 2'd0, 1'b1);
    total++;
    if (m_valid !== 1'b0 || good_cnt !== 4'd0 || bad_cnt !== 4'd0) begin
      bad++;
      $display("FAIL abort_none got v=%0b g=%0d b=%0d want 0 0 0",
               m_valid, good_cnt, bad_cnt);
    end
    head(1'b0, 1'b0);
    tail(1'b0);
    total++;
    if (m_valid !== 1'b1 || m_err !== 1'b0 || m_len !== 5'd13 ||
        good_cnt !== 4'd1) begin
      bad++;
      $display("FAIL abort_next got v=%0b err=%0b len=%0d g=%0d want 1 0 13 1",
               m_valid, m_err, m_len, good_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, fw(0, 1'b0), 1'b0, 2'd0, 1'b0);
    drive(1'b1, fw(0, 1'b1), 1'b0, 2'd0, 1'b0);
    drive(1'b0, fw(1, 1'b0), 1'b0, 2'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || good_cnt !== 4'd0 || bad_cnt !== 4'd0) begin
      bad++;
      $display("FAIL rstmid_clr got v=%0b g=%0d b=%0d want 0 0 0",
               m_valid, good_cnt, bad_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    head(1'b0, 1'b0);
    tail(1'b0);
    total++;
    if (m_err !== 1'b0 || m_len !== 5'd13 || good_cnt !== 4'd1) begin
      bad++;
      $display("FAIL rstmid_ch0 got err=%0b len=%0d g=%0d want 0 13 1",
               m_err, m_len, good_cnt);
    end
    head(1'b1, 1'b0);
    tail(1'b1);
    total++;
    if (m_ch !== 1'b1 || m_err !== 1'b0 || m_len !== 5'd13) begin
      bad++;
      $display("FAIL rstmid_ch1 got ch=%0d err=%0b len=%0d want 1 0 13",
               m_ch, m_err, m_len);
    end
    @(negedge clk);
  endtask

  task automatic test_short();
    drive(1'b0, 32'h0000_0000, 1'b1, 2'd0, 1'b0);
    total++;
    if (m_err !== 1'b0 || m_len !== 5'd4) begin
      bad++;
      $display("FAIL short_zero got err=%0b len=%0d want 0 4", m_err, m_len);
    end
    drive(1'b0, 32'h3132_3334, 1'b1, 2'd0, 1'b0);
    total++;
    if (m_err !== 1'b1 || m_len !== 5'd4) begin
      bad++;
      $display("FAIL short_bad got err=%0b len=%0d want 1 4", m_err, m_len);
    end
    drive(1'b1, 32'h3132_0000, 1'b1, 2'd2, 1'b0);
    total++;
    if (m_ch !== 1'b1 || m_len !== 5'd2) begin
      bad++;
      $display("FAIL short_two got ch=%0d len=%0d want 1 2", m_ch, m_len);
    end
    @(negedge clk);
  endtask

  task automatic test_len_sat();
    for (int k = 0; k < 7; k++) drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 2'd3, 1'b0);
    total++;
    if (m_len !== 5'd31) begin
      bad++; $display("FAIL len_exact got=%0d want=31", m_len);
    end
    for (int k = 0; k < 10; k++) drive(1'b1, 32'h0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 32'h0, 1'b1, 2'd0, 1'b0);
    total++;
    if (m_len !== 5'd31 || m_ch !== 1'b1) begin
      bad++;
      $display("FAIL len_sat got len=%0d ch=%0d want 31 1", m_len, m_ch);
    end
    @(negedge clk);
  endtask

  task automatic test_cnt_sat();
    int want;
    clear_counters();
    for (int k = 1; k <= 16; k++) begin
      head(1'b0, 1'b0);
      tail(1'b0);
      want = (k > 15) ? 15 : k;
      total++;
      if (good_cnt !== 4'(want)) begin
        bad++;
        $display("FAIL cnt_sat_%0d got=%0d want=%0d", k, good_cnt, want);
      end
    end
    head(1'b0, 1'b1);
    tail(1'b0);
    total++;
    if (good_cnt !== 4'd15 || bad_cnt !== 4'd1) begin
      bad++;
      $display("FAIL cnt_mix got=%0d/%0d want=15/1", good_cnt, bad_cnt);
    end
    head(1'b0, 1'b0);
    clr_cnt = 1'b1;
    tail(1'b0);
    clr_cnt = 1'b0;
    total++;
    if (good_cnt !== 4'd1 || bad_cnt !== 4'd0) begin
      bad++;
      $display("FAIL cnt_clr_hit got=%0d/%0d want=1/0", good_cnt, bad_cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_bnum  = '0;
    s_eof   = 1'b0;
    s_abort = 1'b0;
    s_ch    = '0;
    m_ready = 1'b1;
    clr_cnt = 1'b0;
    test_reset();
    test_good();
    test_bad();
    test_interleave();
    test_stall();
    test_abort();
    test_reset_mid();
    test_short();
    test_len_sat();
    test_cnt_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
